// File: rtl/onehot_decode_accum.sv
// MSB-first index-to-one-hot decoder with optional burst OR-accumulation and popcount.
// Latency: a closing beat accepted at edge N drives out_* right after edge N.
// Backpressure: in_ready = !reset && (!out_valid || out_ready); output held while stalled.
module onehot_decode_accum #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2**IN_W,
    parameter int CNT_W = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_idx,
    input  logic             in_en,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [CNT_W-1:0] out_count
);

    if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
        $error("onehot_decode_accum: IN_W must be in 1..8");
    end
    if (OUT_W != 2**IN_W) begin : g_bad_out_w
        $error("onehot_decode_accum: OUT_W is derived and must not be overridden");
    end

    localparam logic [OUT_W-1:0] TOP_BIT = {1'b1, {(OUT_W-1){1'b0}}};

    function automatic logic [CNT_W-1:0] popcnt(input logic [OUT_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_onehot_q, out_onehot_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [OUT_W-1:0] acc_q, acc_d;

    logic             accept;
    logic             closing;
    logic [OUT_W-1:0] hot;
    logic [OUT_W-1:0] merged;

    assign in_ready = !reset && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // A single-mode beat always closes, which also flushes any burst left pending.
    assign closing  = !mode || in_last;
    assign hot      = in_en ? (TOP_BIT >> in_idx) : '0;
    assign merged   = acc_q | hot;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_onehot_d = out_onehot_q;
        out_count_d  = out_count_q;
        acc_d        = acc_q;
        if (accept && closing) begin
            out_valid_d  = 1'b1;
            out_onehot_d = merged;
            out_count_d  = popcnt(merged);
            acc_d        = '0;
        end else begin
            if (accept) begin
                acc_d = merged;
            end
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_onehot_q <= '0;
            out_count_q  <= '0;
            acc_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_onehot_q <= out_onehot_d;
            out_count_q  <= out_count_d;
            acc_q        <= acc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_onehot = out_onehot_q;
    assign out_count  = out_count_q;

endmodule

// File: tb/tb_onehot_decode_accum.sv
// Self-checking bench: directed scenarios plus randomized traffic against a burst-level model.
module tb_onehot_decode_accum;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_en, in_last, mode, out_valid, out_ready;
    logic [2:0] in_idx;
    logic [7:0] out_onehot;
    logic [3:0] out_count;

    logic        w_valid, w_ready, w_en, w_last, w_mode, w_ovalid, w_oready;
    logic [3:0]  w_idx;
    logic [15:0] w_onehot;
    logic [4:0]  w_count;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] m_acc = 8'h00;
    logic [7:0] m_out = 8'h00;
    int         m_cnt = 0;
    bit         m_vld = 1'b0;

    always #5 clk = ~clk;

    onehot_decode_accum #(.IN_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_en(in_en), .in_last(in_last), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_count(out_count)
    );

    onehot_decode_accum #(.IN_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(w_valid), .in_ready(w_ready),
        .in_idx(w_idx), .in_en(w_en), .in_last(w_last), .mode(w_mode),
        .out_valid(w_ovalid), .out_ready(w_oready),
        .out_onehot(w_onehot), .out_count(w_count)
    );

    task automatic drive(input bit v, input int idx, input bit en, input bit last,
                         input bit md, input bit ordy);
        in_valid  = v;
        in_idx    = 3'(idx);
        in_en     = en;
        in_last   = last;
        mode      = md;
        out_ready = ordy;
    endtask

    // Advance one clock; the model applies the burst rules to the beat presented this cycle.
    task automatic tick();
        bit         take;
        logic [7:0] hot;
        take = in_valid && !reset && (!m_vld || out_ready);
        hot  = in_en ? 8'(1 << (7 - int'(in_idx))) : 8'h00;
        @(posedge clk);
        if (reset) begin
            m_acc = 8'h00; m_out = 8'h00; m_cnt = 0; m_vld = 1'b0;
        end else if (take && (!mode || in_last)) begin
            m_out = m_acc | hot; m_cnt = $countones(m_acc | hot); m_vld = 1'b1; m_acc = 8'h00;
        end else begin
            if (take) m_acc = m_acc | hot;
            if (out_ready) m_vld = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 1);
        w_valid = 0; w_idx = '0; w_en = 1; w_last = 0; w_mode = 0; w_oready = 1;
        tick(); #1;
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (out_onehot !== 8'h00 || out_count !== 4'd0) begin errors++;
            $display("FAIL reset_data: got %h/%0d want 00/0", out_onehot, out_count); end
        @(negedge clk);
        reset = 1'b0; #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single_b2b();
        int         idxs [3] = '{0, 3, 7};
        logic [7:0] exp  [3] = '{8'h80, 8'h10, 8'h01};
        for (int i = 0; i < 3; i++) begin
            drive(1, idxs[i], 1, 0, 0, 1);
            tick();
            vectors++; if (out_valid !== 1'b1 || out_onehot !== exp[i] || out_count !== 4'd1) begin errors++;
                $display("FAIL single_idx%0d: got v=%b %h/%0d want v=1 %h/1", idxs[i], out_valid, out_onehot, out_count, exp[i]); end
        end
        drive(0, 0, 1, 0, 0, 1);
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_accumulate();
        drive(1, 2, 1, 0, 1, 1); tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL accum_beat1: got valid %b want 0", out_valid); end
        drive(1, 5, 1, 0, 1, 1); tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL accum_beat2: got valid %b want 0", out_valid); end
        drive(1, 2, 1, 1, 1, 1); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'b0010_0100 || out_count !== 4'd2) begin errors++;
            $display("FAIL accum_burst: got v=%b %b/%0d want v=1 00100100/2", out_valid, out_onehot, out_count); end
        drive(1, 7, 1, 1, 1, 1); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'h01 || out_count !== 4'd1) begin errors++;
            $display("FAIL accum_cleared: got v=%b %h/%0d want v=1 01/1", out_valid, out_onehot, out_count); end
        drive(0, 0, 1, 0, 0, 1); tick();
    endtask

    task automatic test_backpressure();
        drive(1, 1, 1, 0, 0, 0); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'h40) begin errors++;
            $display("FAIL bp_first: got v=%b %h want v=1 40", out_valid, out_onehot); end
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b want 0", i, in_ready); end
            tick();
            vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'h40 || out_count !== 4'd1) begin errors++;
                $display("FAIL bp_hold_%0d: got v=%b %h/%0d want v=1 40/1", i, out_valid, out_onehot, out_count); end
        end
        out_ready = 1'b1; #1;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'h40) begin errors++;
            $display("FAIL bp_swap: got v=%b %h want v=1 40", out_valid, out_onehot); end
        drive(1, 6, 1, 0, 0, 1); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'h02) begin errors++;
            $display("FAIL bp_replace: got v=%b %h want v=1 02", out_valid, out_onehot); end
        drive(0, 0, 1, 0, 0, 1); tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_enable();
        drive(1, 4, 0, 0, 1, 1); tick();
        drive(1, 6, 1, 1, 1, 1); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'b0000_0010 || out_count !== 4'd1) begin errors++;
            $display("FAIL en_burst: got v=%b %b/%0d want v=1 00000010/1", out_valid, out_onehot, out_count); end
        drive(1, 3, 0, 0, 0, 1); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'h00 || out_count !== 4'd0) begin errors++;
            $display("FAIL en_zero_beat: got v=%b %h/%0d want v=1 00/0", out_valid, out_onehot, out_count); end
        drive(0, 0, 1, 0, 0, 1); tick();
    endtask

    task automatic test_mode_switch();
        drive(1, 0, 1, 0, 1, 1); tick();
        drive(1, 1, 1, 0, 1, 1); tick();
        drive(1, 7, 1, 0, 0, 1); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'b1100_0001 || out_count !== 4'd3) begin errors++;
            $display("FAIL mode_switch: got v=%b %b/%0d want v=1 11000001/3", out_valid, out_onehot, out_count); end
        drive(0, 0, 1, 0, 0, 1); tick();
    endtask

    task automatic test_reset_midburst();
        drive(1, 3, 1, 0, 1, 1); tick();
        drive(0, 0, 1, 0, 1, 1);
        reset = 1'b1; #1;
        vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_ctrl: got rdy=%b v=%b want 0/0", in_ready, out_valid); end
        vectors++; if (out_onehot !== 8'h00 || out_count !== 4'd0) begin errors++;
            $display("FAIL rst_mid_data: got %h/%0d want 00/0", out_onehot, out_count); end
        tick();
        reset = 1'b0;
        drive(1, 5, 1, 1, 1, 1); tick();
        vectors++; if (out_valid !== 1'b1 || out_onehot !== 8'b0000_0100 || out_count !== 4'd1) begin errors++;
            $display("FAIL rst_mid_after: got v=%b %b/%0d want v=1 00000100/1", out_valid, out_onehot, out_count); end
        drive(0, 0, 1, 0, 0, 1); tick();
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !reset && (!m_vld || out_ready);
            vectors++; if (in_ready !== exp_rdy) begin errors++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", n, in_ready, exp_rdy); end
            tick();
            vectors++; if (out_valid !== m_vld) begin errors++;
                $display("FAIL rand_out_valid[%0d]: got %b want %b", n, out_valid, m_vld); end
            if (m_vld) begin
                vectors++; if (out_onehot !== m_out || out_count !== 4'(m_cnt)) begin errors++;
                    $display("FAIL rand_data[%0d]: got %h/%0d want %h/%0d", n, out_onehot, out_count, m_out, m_cnt); end
            end
        end
        reset = 1'b0;
        drive(0, 0, 1, 0, 0, 1); tick();
    endtask

    task automatic test_inw4();
        w_valid = 1; w_idx = 4'd0; w_en = 1; w_last = 0; w_mode = 0; w_oready = 1;
        @(posedge clk); @(negedge clk);
        vectors++; if (w_ovalid !== 1'b1 || w_onehot !== 16'h8000 || w_count !== 5'd1) begin errors++;
            $display("FAIL w4_idx0: got v=%b %h/%0d want v=1 8000/1", w_ovalid, w_onehot, w_count); end
        w_idx = 4'd15;
        @(posedge clk); @(negedge clk);
        vectors++; if (w_onehot !== 16'h0001 || w_count !== 5'd1) begin errors++;
            $display("FAIL w4_idx15: got %h/%0d want 0001/1", w_onehot, w_count); end
        w_mode = 1;
        for (int i = 0; i < 16; i++) begin
            w_idx = 4'(i); w_last = (i == 15);
            @(posedge clk); @(negedge clk);
        end
        vectors++; if (w_ovalid !== 1'b1 || w_onehot !== 16'hFFFF || w_count !== 5'd16) begin errors++;
            $display("FAIL w4_full_burst: got v=%b %h/%0d want v=1 ffff/16", w_ovalid, w_onehot, w_count); end
        w_valid = 0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_b2b();
        test_accumulate();
        test_backpressure();
        test_enable();
        test_mode_switch();
        test_reset_midburst();
        test_random();
        test_inw4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/onehot_decode_accum.md
# onehot_decode_accum

Parametrised, registered index-to-one-hot decoder with a valid/ready stream interface and an optional burst-accumulate mode. Each beat carries an `IN_W`-bit index. The block emits either one one-hot word per beat, or the OR of all one-hot words in a burst, together with the popcount of the emitted word. It sits between the bit-serial index generators and the PE-column select/mask logic, and replaces fixed-width combinational decoders on those paths.

## Interface
Parameters:
- `IN_W`, 3: index width; legal range 1..8. Elaboration error outside that range.
- `OUT_W`, `2**IN_W`: one-hot width. Derived; must not be overridden.
- `CNT_W`, `$clog2(OUT_W+1)`: popcount width. Derived.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_idx`  in  `IN_W`  index to decode.
- `in_en`  in  1  1: index contributes its bit; 0: beat contributes all-zeros.
- `in_last`  in  1  last beat of a burst (accumulate mode only).
- `mode`  in  1  0 = single (one output per beat); 1 = accumulate (one output per burst). Sampled per accepted beat.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_onehot`  out  `OUT_W`  decoded / accumulated mask.
- `out_count`  out  `CNT_W`  number of set bits in `out_onehot`.

## Operation
- Decode mapping is MSB-first: index `i` sets bit `OUT_W-1-i`. For `IN_W=3`: idx 0 → 8'b1000_0000; idx 7 → 8'b0000_0001.
- Beat contribution `hot = in_en ? onehot(in_idx) : 0`.
- Internal accumulator `acc[OUT_W-1:0]` holds the OR of the accepted beats of the burst in progress.
- An accepted beat "closes" when `mode==0`, or when `mode==1 && in_last`. `in_last` is ignored in single mode.
- Closing beat:
  - Output register loads `acc | hot`.
  - `out_count` loads the popcount of that value.
  - `out_valid` is set to 1.
  - `acc` clears to 0.
- Non-closing beat (`mode==1`, `in_last==0`): `acc <= acc | hot`. The output register is unchanged.
- Mode switch mid-burst: a single-mode beat arriving while `acc != 0` closes the pending burst. Its output is `acc | hot`, and no bits are lost. A burst must otherwise hold `mode` constant.
- Duplicate indices within a burst OR together. The count reflects distinct bits only: idx 2,2 gives count 1.
- A closing beat with all contributions disabled emits `out_onehot=0`, `out_count=0`, `out_valid=1`.
- Flow control:
  - `in_ready = !reset && (!out_valid || out_ready)`.
  - This holds for all beats, closing or not, and does not depend on `in_last`, `in_idx` or `mode`.
- Output hold: while `out_valid && !out_ready`, `out_onehot` and `out_count` are held stable.
- Simultaneous output drain and closing-beat acceptance in one cycle: the new word replaces the old one, and `out_valid` stays 1.
- Drain with no new closing beat: `out_valid` falls to 0. The data registers may hold their stale value.

## Timing
- Reset (asynchronous assert, synchronous release from the next edge):
  - `out_valid=0`, `out_onehot=0`, `out_count=0`, `acc=0`.
  - `in_ready=0` while `reset` is high.
- Reset mid-burst discards the partial `acc` and any unread output word.
- Latency: a closing beat accepted at edge N is visible on `out_*` immediately after edge N, with `out_valid=1` in cycle N+1.
- Throughput is one beat per cycle with `out_ready` held high. In single mode this is one output per cycle; in accumulate mode, one output per burst.
- No combinational path from `in_*` to `out_*`.
- The only combinational input-to-output path is `out_ready` → `in_ready`.

## Test plan
- Single mode, `IN_W=3`, idx 0,3,7 on back-to-back cycles with `out_ready=1` → outputs 8'h80, 8'h10, 8'h01, each count 1, one cycle after each accept, with no bubbles.
- Accumulate mode, idx 2,5,2(last) → no output for the first two beats, then one output 8'b0010_0100 with count 2. The next burst, idx 7(last), yields 8'h01 count 1, showing `acc` was cleared.
- Backpressure: `out_ready=0` for 4 cycles after output 8'h40 → `out_*` held stable and `in_ready=0`. Raising `out_ready` with a closing beat idx 1 pending → 8'h40 is taken and 8'h40 (idx 1) is loaded in the same edge, and `out_valid` stays 1.
- `in_en=0` handling: accumulate burst idx 4(en=0), idx 6(en=1, last) → 8'b0000_0010, count 1. A lone single-mode beat with en=0 → 8'h00, count 0, `out_valid=1`.
- Mode switch and reset: accumulate beats idx 0,1, then a single-mode beat idx 7 → 8'b1100_0001, count 3. Separately, assert `reset` after accumulating idx 3 → all outputs 0 and `in_ready=0` during reset. After release, accumulate idx 5(last) → 8'b0000_0100 only.
- `IN_W=4` build: idx 0 → 16'h8000, idx 15 → 16'h0001. An accumulate burst of all 16 indices → 16'hFFFF, count 16 (`CNT_W=5`).
